// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port word memory between instruction
//                fetch (0), load/store (1) and the debug loader (2). Fixed
//                priority 1 > 0 > 2 with starvation aging, read-return
//                tagging, and an exclusive loader mode that drains reads
//                before locking the processor out.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1,
    parameter int MAX_WAIT = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              req,
    input  logic [2:0]              req_we,
    input  logic [3*ADDR_W-1:0]     req_addr,
    input  logic [3*DATA_W/8-1:0]   req_be,
    input  logic [3*DATA_W-1:0]     req_wdata,
    output logic [2:0]              gnt,
    output logic [2:0]              rvalid,
    output logic [DATA_W-1:0]       rdata,
    input  logic                    excl_req,
    output logic                    excl_ack,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W/8-1:0]     mem_be,
    output logic                    mem_we,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata
);

    localparam int         c_be_w     = DATA_W / 8;
    localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);
    localparam logic [3:0] c_wait_sat = 4'hF;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_EXCL  = 2'd2
    } state_t;

    state_t                    r_state;
    logic                      r_excl_ack;
    logic [2:0][3:0]           r_wait_cnt;
    logic [READ_LAT-1:0][2:0]  r_tag_pipe;
    logic [2:0]                r_rvalid;
    logic [DATA_W-1:0]         r_rdata;

    logic [2:0]                w_starved;
    logic [2:0]                w_cand;
    logic [2:0]                w_gnt;
    logic [2:0]                w_rd_tag;
    logic                      w_pipe_empty;

    // A requester is starved once it has been denied MAX_WAIT cycles in a row
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_starved
            assign w_starved[gi] = req[gi] && (r_wait_cnt[gi] >= c_max_wait);
        end
    endgenerate

    // Pick the winner: starved requesters first, base priority 1 > 0 > 2
    always_comb begin
        w_cand = (|w_starved) ? w_starved : req;
        w_gnt  = 3'b000;
        if (!reset) begin
            case (r_state)
                ST_ARB: begin
                    if (w_cand[1])      w_gnt = 3'b010;
                    else if (w_cand[0]) w_gnt = 3'b001;
                    else if (w_cand[2]) w_gnt = 3'b100;
                end
                ST_EXCL: w_gnt = {req[2], 2'b00};
                default: w_gnt = 3'b000;
            endcase
        end
    end

    assign gnt          = w_gnt;
    assign w_rd_tag     = w_gnt & ~req_we;
    assign w_pipe_empty = (r_tag_pipe == '0);

    // Route the winning requester onto the memory port; idle port is all zero
    always_comb begin
        mem_addr  = '0;
        mem_be    = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            if (w_gnt[i]) begin
                mem_addr  = req_addr[i*ADDR_W +: ADDR_W];
                mem_be    = req_be[i*c_be_w +: c_be_w];
                mem_we    = req_we[i];
                mem_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Aging counters; the processor ports are frozen while the loader owns memory
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_state == ST_EXCL && i != 2) begin
                    r_wait_cnt[i] <= r_wait_cnt[i];
                end else if (req[i] && !w_gnt[i]) begin
                    if (r_wait_cnt[i] != c_wait_sat) begin
                        r_wait_cnt[i] <= r_wait_cnt[i] + 4'd1;
                    end
                end else begin
                    r_wait_cnt[i] <= 4'd0;
                end
            end
        end
    end

    // Read tags travel alongside the memory latency; writes insert an empty slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag_pipe <= '0;
        end else begin
            r_tag_pipe[0] <= w_rd_tag;
            for (int k = 1; k < READ_LAT; k++) begin
                r_tag_pipe[k] <= r_tag_pipe[k-1];
            end
        end
    end

    // Register the returning beat together with the owner's tag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= r_tag_pipe[READ_LAT-1];
            if (|r_tag_pipe[READ_LAT-1]) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;

    // Ownership FSM: enter exclusive mode only once no read is in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_ARB;
            r_excl_ack <= 1'b0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (excl_req) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!excl_req) begin
                        r_state <= ST_ARB;
                    end else if (w_pipe_empty) begin
                        r_state    <= ST_EXCL;
                        r_excl_ack <= 1'b1;
                    end
                end
                ST_EXCL: begin
                    if (!excl_req) begin
                        r_state    <= ST_ARB;
                        r_excl_ack <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_ARB;
                    r_excl_ack <= 1'b0;
                end
            endcase
        end
    end

    assign excl_ack = r_excl_ack;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port 32-bit word memory between three requesters: processor instruction fetch (0), processor load/store (1) and debug/program loader (2). Each cycle it grants one requester under fixed priority with starvation aging, and drives the memory port from the winner. It tags outstanding reads so each rdata beat returns to the right requester. It also supports an exclusive loader mode that drains in-flight reads and then locks out the processor.

Parameters:
ADDR_W, 8, word/byte address width, matching program_counter/access_address
DATA_W, 32, memory data width; byte enables are DATA_W/8
READ_LAT, 1, memory read latency in cycles (legal 1..3)
MAX_WAIT, 3, consecutive denied cycles before a requester is promoted to top priority (legal 1..15)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
req  in  3  per-requester request; held stable until granted
req_we  in  3  per-requester write (1) / read (0)
req_addr  in  3*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_be  in  3*DATA_W/8  packed byte enables
req_wdata  in  3*DATA_W  packed write data
gnt  out  3  one-hot grant, combinational, same cycle as accepted request
rvalid  out  3  one-hot read-data valid, registered
rdata  out  DATA_W  read data, broadcast; qualified by rvalid
excl_req  in  1  loader requests exclusive memory ownership
excl_ack  out  1  exclusive ownership held, registered
mem_addr  out  ADDR_W  memory address (from granted requester, else 0)
mem_be  out  DATA_W/8  memory byte enables (0 when no grant)
mem_we  out  1  memory write strobe, high only for a granted write
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid READ_LAT cycles after the read address

Behaviour:
- Reset values: gnt=0, rvalid=0, rdata=0, excl_ack=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0. State=ARB. Wait counters=0. Read tag pipeline cleared. In-flight reads are discarded, with no rvalid after reset.
- At most one gnt bit per cycle. gnt[i] implies req[i]. A grant completes the transaction in that cycle. The memory port is purely combinational from the winner.
- Base priority in ARB: 1 > 0 > 2.
- Aging: wait_cnt[i] increments, saturating, each cycle req[i]&&!gnt[i]. It clears on gnt[i] or !req[i].
  - A requester with wait_cnt[i] >= MAX_WAIT beats all non-starved requesters.
  - Among several starved requesters, base priority applies.
- Read return: a granted read pushes a one-hot tag into a READ_LAT-deep shift register. Writes push 0.
  - rvalid = tag at depth READ_LAT; rdata = mem_rdata registered with it.
  - Net latency: rvalid[i] rises READ_LAT+1 cycles after gnt[i] cycle (READ_LAT=1 -> 2 cycles).
  - Back-to-back reads by any mix of requesters return in grant order, one per cycle.
- States:
  - ARB: normal arbitration. excl_req=1 -> DRAIN.
  - DRAIN: no grants to anyone. excl_req=0 -> ARB. Tag pipeline empty (no outstanding reads) -> EXCL.
  - EXCL: excl_ack=1. Only requester 2 can be granted, every cycle it requests; requesters 0/1 get no grant and their wait counters are frozen. excl_req=0 -> ARB next cycle, and excl_ack falls in the same edge.
- If excl_req rises with no reads outstanding, DRAIN lasts exactly one cycle. excl_ack rises 2 cycles after excl_req.
- Simultaneous excl_req rise and a pending request in ARB: that cycle still arbitrates normally. Its read, if any, must drain.
- req_addr/req_be/req_wdata for non-granted requesters are ignored. No address checking: out-of-range addresses are passed through untruncated.

Test Plan:
1. After reset, req=3'b011 with both reads, READ_LAT=1 -> gnt=010 cycle 0, gnt=001 cycle 1; rvalid=010 at cycle 2 with mem_rdata of addr1, rvalid=001 at cycle 3.
2. Requester 1 reads continuously, requester 2 holds a write addr 0x40 be=0001 wdata=0xAB, MAX_WAIT=3 -> gnt[2] on the 4th request cycle; mem_we=1, mem_be=0001, mem_addr=0x40 that cycle only.
3. Reads granted in cycles 0,1, excl_req=1 at cycle 1 -> no grants cycles 2-3; EXCL entered when last tag leaves; excl_ack=1 at cycle 4; req=111 -> gnt=100 only.
4. In EXCL drop excl_req -> next cycle excl_ack=0; pending req[1] granted the same cycle state returns to ARB.
5. Assert reset while two reads are outstanding -> rvalid never asserts for them; all outputs take reset values asynchronously; state ARB after release.
6. Write then read same requester back-to-back -> write gets no rvalid; read rvalid exactly READ_LAT+1 cycles after its grant.
